// File: rtl/lcd_16x2_seq.sv
// -----------------------------------------------------------------------------
// lcd_16x2_seq
// Sequencer for a 16x2 HD44780 LCD driven through a single-command writer.
// After reset it waits out the power-up delay, runs the 8-bit init sequence
// (0x38, 0x38, 0x0C, 0x01, 0x06) and then writes 32 characters from an external
// buffer to lines 1 and 2. Each refresh request rewrites the whole screen.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   refresh    one-cycle pulse requesting a full screen rewrite
//   char_addr  buffer read address (0-15 line 1, 16-31 line 2)
//   char_data  buffer read data, combinational from char_addr
//   cmd_word   to writer: [10]=RS, [9]=RW (0), [8]=0, [7:0]=data/command
//   cmd_start  one-cycle start pulse to writer
//   cmd_ready  writer ready (1 = idle/finished)
//   init_done  high once the init sequence has completed
//   busy       high whenever the controller is not idle
// -----------------------------------------------------------------------------
module lcd_16x2_seq #(
  parameter int PWR_UP_CYC   = 750000,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh,
  output logic [4:0]  char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] cmd_word,
  output logic        cmd_start,
  input  logic        cmd_ready,
  output logic        init_done,
  output logic        busy
);

  localparam int MAX_CYC = (PWR_UP_CYC > CLR_WAIT_CYC) ? PWR_UP_CYC : CLR_WAIT_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 20) ? $clog2(MAX_CYC + 1) : 20;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_UP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

  // Index 0 of a line is the DDRAM address command, 1..16 are the characters.
  localparam logic [4:0] INIT_LAST = 5'd4;
  localparam logic [4:0] LINE_LAST = 5'd16;

  typedef enum logic [2:0] {
    S_PWRUP, S_SETUP, S_ISSUE, S_ACK, S_DONE, S_WAIT, S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    PH_INIT, PH_LINE1, PH_LINE2
  } phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [10:0]      cmd_word_q, cmd_word_d;
  logic             cmd_start_q, cmd_start_d;
  logic [4:0]       char_addr_q, char_addr_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] wait_last;
  logic             wait_end;
  logic [3:0]       char_lo;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  endfunction

  // Clear Display needs the long settle time; cmd_word still holds the
  // command that just completed while in WAIT.
  assign wait_last = (!cmd_word_q[10] && cmd_word_q[7:0] == 8'h01) ? CLR_LAST : CMD_LAST;
  assign wait_end  = (state_q == S_WAIT) && (cnt_q == wait_last);
  // idx 1..16 maps to column 0..15 (idx 16 wraps its low nibble to 0, minus 1 = 15).
  assign char_lo   = idx_q[3:0] - 4'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      phase_q     <= PH_INIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      cmd_word_q  <= '0;
      cmd_start_q <= 1'b0;
      char_addr_q <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      cmd_word_q  <= cmd_word_d;
      cmd_start_q <= cmd_start_d;
      char_addr_q <= char_addr_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    cnt_d     = '0;
    pending_d = pending_q;
    if (refresh && state_q != S_IDLE) pending_d = 1'b1;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_SETUP;
          phase_d = PH_INIT;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: if (cmd_ready == 1'b1) state_d = S_ACK;
      S_ACK:   if (cmd_ready == 1'b0) state_d = S_DONE;
      S_DONE:  if (cmd_ready == 1'b1) state_d = S_WAIT;
      S_WAIT: begin
        if (wait_end) begin
          state_d = S_SETUP;
          idx_d   = idx_q + 5'd1;
          case (phase_q)
            PH_INIT: begin
              if (idx_q == INIT_LAST) begin
                // The first screen write satisfies any refresh seen so far.
                phase_d   = PH_LINE1;
                idx_d     = '0;
                pending_d = 1'b0;
              end
            end
            PH_LINE1: begin
              if (idx_q == LINE_LAST) begin
                phase_d = PH_LINE2;
                idx_d   = '0;
              end
            end
            default: begin
              if (idx_q == LINE_LAST) begin
                state_d = S_IDLE;
                idx_d   = '0;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (refresh || pending_q) begin
          state_d   = S_SETUP;
          phase_d   = PH_LINE1;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_word_d  = cmd_word_q;
    cmd_start_d = 1'b0;
    char_addr_d = char_addr_q;
    init_done_d = init_done_q;
    busy_d      = (state_d != S_IDLE);

    // Present the buffer address one cycle ahead so char_data is settled at ISSUE.
    if (state_q == S_SETUP && phase_q != PH_INIT && idx_q != 5'd0)
      char_addr_d = {phase_q == PH_LINE2, char_lo};

    if (state_q == S_ISSUE && cmd_ready == 1'b1) begin
      cmd_start_d = 1'b1;
      case (phase_q)
        PH_INIT:  cmd_word_d = {3'b000, init_cmd(idx_q[2:0])};
        PH_LINE1: cmd_word_d = (idx_q == 5'd0) ? 11'h080 : {3'b100, char_data};
        default:  cmd_word_d = (idx_q == 5'd0) ? 11'h0C0 : {3'b100, char_data};
      endcase
    end

    if (wait_end && phase_q == PH_INIT && idx_q == INIT_LAST)
      init_done_d = 1'b1;
  end

  assign cmd_word  = cmd_word_q;
  assign cmd_start = cmd_start_q;
  assign char_addr = char_addr_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_16x2_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_16x2_seq
// Self-checking bench for lcd_16x2_seq with short timing parameters, a
// behavioural command writer (ready low 30 cycles per command, optionally one
// 500-cycle stall) and a 32-byte character buffer. Expected command streams are
// built from the display rules (init list, line address + 16 chars per line).
// -----------------------------------------------------------------------------
module tb_lcd_16x2_seq;

  localparam int PWR = 10;
  localparam int CMDW = 5;
  localparam int CLRW = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh = 1'b0;
  logic [4:0]  char_addr;
  logic [7:0]  char_data;
  logic [10:0] cmd_word;
  logic        cmd_start;
  logic        cmd_ready = 1'b1;
  logic        init_done;
  logic        busy;

  logic [7:0]  mem_buf [32];
  assign char_data = mem_buf[char_addr];

  lcd_16x2_seq #(
    .PWR_UP_CYC  (PWR),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .refresh  (refresh),
    .char_addr(char_addr),
    .char_data(char_data),
    .cmd_word (cmd_word),
    .cmd_start(cmd_start),
    .cmd_ready(cmd_ready),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Start log
  int          cyc = 0;
  int          nstarts = 0;
  int          idle_run = 0;
  logic [10:0] q_word[$];
  int          q_cyc[$];
  int          q_gap[$];
  logic        q_done[$];
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      idle_run <= 0;
    end else if (cmd_start === 1'b1) begin
      q_word.push_back(cmd_word);
      q_cyc.push_back(cyc);
      q_gap.push_back(idle_run);
      q_done.push_back(init_done);
      nstarts  <= nstarts + 1;
      idle_run <= 0;
    end else if (cmd_ready === 1'b1) begin
      idle_run <= idle_run + 1;
    end
  end

  // Writer model
  int wr_cnt = 0;
  int stall_idx = -1;
  always @(posedge clk) begin
    if (wr_cnt > 1) begin
      wr_cnt <= wr_cnt - 1;
    end else if (wr_cnt == 1) begin
      wr_cnt    <= 0;
      cmd_ready <= 1'b1;
    end else if (cmd_start === 1'b1) begin
      cmd_ready <= 1'b0;
      wr_cnt    <= (nstarts - 1 == stall_idx) ? 500 : 30;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (nstarts < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_starts_reached"}, nstarts >= n, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_idle_reached"}, busy, 0);
  endtask

  task automatic push_init();
    exp_q.push_back(11'h038);
    exp_q.push_back(11'h038);
    exp_q.push_back(11'h00C);
    exp_q.push_back(11'h001);
    exp_q.push_back(11'h006);
  endtask

  task automatic push_screen();
    exp_q.push_back(11'h080);
    for (int a = 0; a < 16; a++) exp_q.push_back({3'b100, mem_buf[a]});
    exp_q.push_back(11'h0C0);
    for (int a = 16; a < 32; a++) exp_q.push_back({3'b100, mem_buf[a]});
  endtask

  // Compare logged starts [base, base+size) against exp_q; check settle gaps.
  task automatic compare_seq(input string tag, input int base);
    int mn;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < q_word.size()) begin
        chk($sformatf("%s_word%0d", tag, i), {21'd0, q_word[base + i]}, {21'd0, exp_q[i]});
        if (i > 0) begin
          mn = (exp_q[i - 1] == 11'h001) ? CLRW : CMDW;
          chk($sformatf("%s_gap%0d_min%0d_was%0d", tag, i, mn, q_gap[base + i]),
              q_gap[base + i] >= mn, 1);
        end
      end else begin
        chk($sformatf("%s_word%0d_missing", tag, i), 0, 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_start"}, cmd_start, 0);
    chk({tag, "_cmd_word"}, cmd_word, 0);
    chk({tag, "_char_addr"}, char_addr, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic randomize_buf();
    for (int a = 0; a < 32; a++) mem_buf[a] = 8'($urandom);
  endtask

  initial begin
    int base;
    int rel_cyc;
    int n0;
    int bad;
    logic [10:0] w;

    for (int a = 0; a < 32; a++) mem_buf[a] = 8'(8'h41 + a);

    // Reset values
    ticks(3);
    check_reset_outputs("reset");

    // Power-up, init sequence and first screen
    rst_n = 1'b1;
    rel_cyc = cyc;
    push_init();
    push_screen();
    wait_starts("boot", 39, 4000);
    if (q_cyc.size() > 0)
      chk($sformatf("pwrup_delay_%0d", q_cyc[0] - rel_cyc), (q_cyc[0] - rel_cyc) >= PWR, 1);
    compare_seq("boot", 0);
    if (q_done.size() > 5) begin
      chk("init_done_at_0x006", q_done[4], 0);
      chk("init_done_at_0x080", q_done[5], 1);
    end
    wait_idle("boot", 500);
    ticks(200);
    chk("boot_no_extra_starts", nstarts, 39);
    chk("init_done_held", init_done, 1);

    // Refresh from idle, random buffer
    randomize_buf();
    exp_q.delete();
    push_screen();
    ticks($urandom_range(1, 50));
    base = nstarts;
    pulse_refresh();
    ticks(2);
    chk("refresh_busy_high", busy, 1);
    wait_starts("ref1", base + 34, 3000);
    compare_seq("ref1", base);
    wait_idle("ref1", 500);
    ticks(150);
    chk("ref1_exact_34", nstarts - base, 34);

    // Three refresh pulses during a rewrite coalesce into one more rewrite
    randomize_buf();
    exp_q.delete();
    push_screen();
    push_screen();
    base = nstarts;
    pulse_refresh();
    for (int p = 0; p < 3; p++) begin
      ticks($urandom_range(30, 300));
      pulse_refresh();
    end
    wait_starts("ref3", base + 68, 6000);
    compare_seq("ref3", base);
    wait_idle("ref3", 3000);
    ticks(200);
    chk("ref3_exact_68", nstarts - base, 68);

    // Writer stall of 500 cycles on the third command of a rewrite
    randomize_buf();
    exp_q.delete();
    push_screen();
    base = nstarts;
    stall_idx = base + 2;
    pulse_refresh();
    wait_starts("stall_pre", base + 3, 1000);
    bad = 0;
    while (cmd_ready !== 1'b0 && bad < 10) begin
      tick();
      bad++;
    end
    w = cmd_word;
    n0 = nstarts;
    bad = 0;
    for (int i = 0; i < 480; i++) begin
      tick();
      if (cmd_word !== w || nstarts != n0 || cmd_ready !== 1'b0) bad++;
    end
    chk("stall_word_stable_no_start", bad, 0);
    wait_starts("stall", base + 34, 3000);
    compare_seq("stall", base);
    wait_idle("stall", 500);
    stall_idx = -1;

    // Reset in the middle of a character, refresh latched during power-up
    exp_q.delete();
    base = nstarts;
    pulse_refresh();
    wait_starts("rst_pre", base + 5, 1000);
    bad = 0;
    while (cmd_ready !== 1'b0 && bad < 10) begin
      tick();
      bad++;
    end
    ticks(3);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    ticks(2);
    rst_n = 1'b1;
    rel_cyc = cyc;
    base = nstarts;
    ticks(3);
    pulse_refresh();
    push_init();
    push_screen();
    wait_starts("restart", base + 39, 5000);
    if (q_cyc.size() > base)
      chk($sformatf("restart_pwrup_delay_%0d", q_cyc[base] - rel_cyc), (q_cyc[base] - rel_cyc) >= PWR, 1);
    compare_seq("restart", base);
    wait_idle("restart", 500);
    ticks(200);
    chk("restart_pending_cleared", nstarts - base, 39);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_16x2_seq.md
Name: lcd_16x2_seq

Overview:
- Sequencer for the 16x2 LCD single-command writer (11-bit command word plus start/ready handshake).
- After reset it waits out the power-up delay, then issues the HD44780 8-bit init sequence.
- It then writes 32 characters from an external character buffer to lines 1 and 2.
- It rewrites the screen on each refresh request.
- Sits between the application's display buffer and the LCD command writer; one instance per display.

Parameters:
- PWR_UP_CYC, 750000, cycles to wait after reset before the first command (15 ms @ 50 MHz)
- CMD_WAIT_CYC, 2000, cycles to wait after each ordinary command/char completes (40 us)
- CLR_WAIT_CYC, 82000, cycles to wait after Clear Display (0x01) completes (1.64 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- refresh  in  1  one-cycle pulse: rewrite all 32 characters
- char_addr  out  5  buffer read address (0-15 line 1, 16-31 line 2)
- char_data  in  8  buffer read data, combinational from char_addr, valid same cycle
- cmd_word  out  11  to writer: [10]=RS, [9]=RW, [8]=0, [7:0]=data/command
- cmd_start  out  1  one-cycle start pulse to writer
- cmd_ready  in  1  writer ready (1 = idle/finished)
- init_done  out  1  high once the init sequence has completed; stays high until reset
- busy  out  1  high whenever the controller is not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge), all registered:
  - state=PWRUP; cmd_start=0; cmd_word=0; char_addr=0; init_done=0; busy=1; refresh_pending=0; counters=0.
  - Reset mid-operation abandons the current command immediately.
  - The controller must not pulse cmd_start again until PWRUP elapses and cmd_ready=1.
- Command issue sub-sequence, used for every command/char:
  - ISSUE: wait for cmd_ready==1 (X/0 counts as not ready), then drive cmd_word and cmd_start=1 for exactly one cycle.
  - ACK: wait for cmd_ready==0. cmd_word is held stable from ISSUE until DONE.
  - DONE: wait for cmd_ready==1.
  - WAIT: count CMD_WAIT_CYC cycles, or CLR_WAIT_CYC if the command was 0x01 with RS=0. Then advance.
  - The first ISSUE cycle with cmd_ready=1 is the start cycle; no extra latency.
- Top-level states:
  - PWRUP: count PWR_UP_CYC cycles, then INIT.
  - INIT: issue RS=0 commands in order 0x38, 0x38, 0x0C, 0x01, 0x06 (index 0-4). After 0x06, set init_done=1 and go to LINE1.
  - LINE1: issue 0x80 (RS=0), then chars for addr 0-15 (RS=1, data=char_data), then LINE2.
  - LINE2: issue 0xC0 (RS=0), then chars for addr 16-31, then IDLE.
  - IDLE: busy=0. If refresh or refresh_pending, clear refresh_pending and go to LINE1 next cycle.
- Character timing: char_addr is set one cycle before ISSUE. char_data is registered into cmd_word[7:0] on the start cycle.
- Refresh while busy: set refresh_pending. Multiple pulses coalesce into one pending rewrite, serviced on reaching IDLE. Refresh during PWRUP/INIT is also latched; the first screen write occurs anyway and satisfies it, so clear pending on entering LINE1.
- Refresh and reaching IDLE on the same cycle: the rewrite starts; no pulse is lost.
- Wrap-around: char_addr never exceeds 31; after 31 the controller returns to IDLE, never addr 0.
- Wait counters are wide enough for max(PWR_UP_CYC, CLR_WAIT_CYC), minimum 20 bits. Terminal count is equal-compare, counting from 0 to N-1.
- cmd_word[9] (RW) is always 0; cmd_word[8] is always 0.

Test Plan:
Bench uses PWR_UP_CYC=10, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20, a behavioural writer model (ready low 30 cycles after start), and buffer data = 0x41+addr.
- Reset release: no cmd_start for 10 cycles. Then 5 starts with cmd_word 0x038, 0x038, 0x00C, 0x001, 0x006. The gap after 0x001 is at least 20 idle cycles; the other gaps are at least 5. init_done rises after 0x006.
- Screen write: following init there are 34 starts: 0x080, 0x441..0x450, 0x0C0, 0x451..0x460. Then busy=0 and no further starts.
- Refresh in IDLE: one pulse produces exactly 34 starts, beginning with 0x080; busy is high during the rewrite.
- Three refresh pulses during a rewrite: exactly one additional 34-command rewrite follows.
- Reset asserted mid-character (after ACK): outputs return to reset values next cycle; the sequence restarts from PWRUP with 0x038.
- Writer stalls cmd_ready low 500 cycles: no new cmd_start and cmd_word stable throughout; resumes normally afterwards.
